// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the writeback port arbiter
package wb_pkg;

   localparam int         WB_XLEN  = 32;
   localparam logic [4:0] REG_X0   = 5'd0;
   localparam int         WB_LANES = 2;

   typedef struct packed {
      logic               valid;
      logic [4:0]         rd;
      logic [WB_XLEN-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/wb_pending_fifo.sv
// rtl/wb_pending_fifo.sv - in-order pending write FIFO with dual push and full entry visibility
module wb_pending_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_push0,
   input  logic [4:0]      i_push0_rd,
   input  logic [XLEN-1:0] i_push0_data,
   input  logic            i_push1,
   input  logic [4:0]      i_push1_rd,
   input  logic [XLEN-1:0] i_push1_data,
   input  logic            i_pop,
   output logic [PW-1:0]   o_rptr,
   output logic [CW-1:0]   o_count,
   output logic [4:0]      o_ent_rd   [DEPTH],
   output logic [XLEN-1:0] o_ent_data [DEPTH]
);

   logic [4:0]      r_rd   [DEPTH];
   logic [XLEN-1:0] r_data [DEPTH];
   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;
   logic [PW-1:0]   w_wptr_p1;

   assign w_wptr_p1 = r_wptr + PW'(1);

   // Entry storage: push1 always lands directly behind push0.
   always_ff @(posedge clk) begin
      if (i_push0) begin
         r_rd[r_wptr]   <= i_push0_rd;
         r_data[r_wptr] <= i_push0_data;
      end
      if (i_push1) begin
         r_rd[w_wptr_p1]   <= i_push1_rd;
         r_data[w_wptr_p1] <= i_push1_data;
      end
   end

   // Pointers and occupancy; wrap is modulo DEPTH through the pointer width.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_wptr  <= r_wptr + PW'(i_push0) + PW'(i_push1);
         r_rptr  <= r_rptr + PW'(i_pop);
         r_count <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(i_pop);
      end
   end

   // Simulation guards: no push past capacity, no pop from empty, push1 only with push0.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (int'(r_count) + int'(i_push0) + int'(i_push1) - int'(i_pop) <= DEPTH);
         assert (!(i_pop && r_count == '0));
         assert (!(i_push1 && !i_push0));
      end
   end

   assign o_rptr     = r_rptr;
   assign o_count    = r_count;
   assign o_ent_rd   = r_rd;
   assign o_ent_data = r_data;

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - dual-lane writeback arbiter onto one regfile port; WB_WAW_COALESCE_EN merges same-rd lane pairs
module wb_port_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wb0_valid_i,
   input  logic [4:0]              wb0_rd_i,
   input  logic [XLEN-1:0]         wb0_data_i,
   input  logic                    wb1_valid_i,
   input  logic [4:0]              wb1_rd_i,
   input  logic [XLEN-1:0]         wb1_data_i,
   output logic                    we3_o,
   output logic [4:0]              a3_o,
   output logic [XLEN-1:0]         wd3_o,
   output logic                    stall_o,
   input  logic [4:0]              rs1_i,
   input  logic [4:0]              rs2_i,
   output logic                    fwd1_hit_o,
   output logic [XLEN-1:0]         fwd1_data_o,
   output logic                    fwd2_hit_o,
   output logic [XLEN-1:0]         fwd2_data_o,
   output logic [$clog2(DEPTH):0]  pending_cnt_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [1:0]      r_rst_sync;
   logic            w_rst_n;
   logic            w_live;
   logic            w_stall;
   logic [PW-1:0]   w_rptr;
   logic [CW-1:0]   w_cnt;
   logic [4:0]      w_ent_rd   [DEPTH];
   logic [XLEN-1:0] w_ent_data [DEPTH];

   logic            w_take      [WB_LANES];
   logic [4:0]      w_lane_rd   [WB_LANES];
   logic [XLEN-1:0] w_lane_data [WB_LANES];
   logic            w_take0_raw;

   logic            w_pop;
   logic            w_we;
   logic [4:0]      w_a3;
   logic [XLEN-1:0] w_wd;
   logic            w_p0;
   logic [4:0]      w_p0_rd;
   logic [XLEN-1:0] w_p0_data;
   logic            w_p1;
   logic [4:0]      w_p1_rd;
   logic [XLEN-1:0] w_p1_data;
   logic [XLEN:0]   w_look1;
   logic [XLEN:0]   w_look2;

   // Reset synchronizer: assertion is immediate, release is aligned to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_rst_n = r_rst_sync[1];
   assign w_live  = rst_n & w_rst_n;

   // Fewer than two free slots means a dual push could overflow, so hold upstream.
   assign w_stall = (DEPTH - int'(w_cnt)) < 2;

   assign w_lane_rd[0]   = wb0_rd_i;
   assign w_lane_rd[1]   = wb1_rd_i;
   assign w_lane_data[0] = wb0_data_i;
   assign w_lane_data[1] = wb1_data_i;

   assign w_take[1]   = w_live & ~w_stall & wb1_valid_i & (wb1_rd_i != REG_X0);
   assign w_take0_raw = w_live & ~w_stall & wb0_valid_i & (wb0_rd_i != REG_X0);

`ifdef WB_WAW_COALESCE_EN
   // Older lane is dead when the younger lane overwrites the same register this cycle.
   assign w_take[0] = w_take0_raw & ~(w_take[1] & (wb0_rd_i == wb1_rd_i));
`else
   assign w_take[0] = w_take0_raw;
`endif

   // Order list: FIFO head first, then lane 0, then lane 1; first goes to the port, rest are queued.
   always_comb begin
      w_pop     = 1'b0;
      w_we      = 1'b0;
      w_a3      = '0;
      w_wd      = '0;
      w_p0      = 1'b0;
      w_p0_rd   = '0;
      w_p0_data = '0;
      w_p1      = 1'b0;
      w_p1_rd   = '0;
      w_p1_data = '0;
      if (w_cnt != '0) begin
         w_pop = 1'b1;
         w_we  = 1'b1;
         w_a3  = w_ent_rd[w_rptr];
         w_wd  = w_ent_data[w_rptr];
         if (w_take[0]) begin
            w_p0      = 1'b1;
            w_p0_rd   = w_lane_rd[0];
            w_p0_data = w_lane_data[0];
            if (w_take[1]) begin
               w_p1      = 1'b1;
               w_p1_rd   = w_lane_rd[1];
               w_p1_data = w_lane_data[1];
            end
         end else if (w_take[1]) begin
            w_p0      = 1'b1;
            w_p0_rd   = w_lane_rd[1];
            w_p0_data = w_lane_data[1];
         end
      end else if (w_take[0]) begin
         w_we = 1'b1;
         w_a3 = w_lane_rd[0];
         w_wd = w_lane_data[0];
         if (w_take[1]) begin
            w_p0      = 1'b1;
            w_p0_rd   = w_lane_rd[1];
            w_p0_data = w_lane_data[1];
         end
      end else if (w_take[1]) begin
         w_we = 1'b1;
         w_a3 = w_lane_rd[1];
         w_wd = w_lane_data[1];
      end
   end

   wb_pending_fifo #(
      .DEPTH (DEPTH),
      .XLEN  (XLEN)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (w_rst_n),
      .i_push0      (w_p0),
      .i_push0_rd   (w_p0_rd),
      .i_push0_data (w_p0_data),
      .i_push1      (w_p1),
      .i_push1_rd   (w_p1_rd),
      .i_push1_data (w_p1_data),
      .i_pop        (w_pop),
      .o_rptr       (w_rptr),
      .o_count      (w_cnt),
      .o_ent_rd     (w_ent_rd),
      .o_ent_data   (w_ent_data)
   );

   // Youngest pending value for rs: FIFO beyond the head (oldest to youngest), then queued lanes.
   // The head and the directly-written lane are excluded because the regfile takes them this edge.
   function automatic logic [XLEN:0] f_lookup(input logic [4:0] rs);
      logic [XLEN:0] res;
      logic [PW-1:0] idx;
      res = '0;
      idx = '0;
      if (rs != REG_X0) begin
         for (int i = 1; i < DEPTH; i++) begin
            if (i < int'(w_cnt)) begin
               idx = w_rptr + PW'(i);
               if (w_ent_rd[idx] == rs) res = {1'b1, w_ent_data[idx]};
            end
         end
         if (w_p0 && w_p0_rd == rs) res = {1'b1, w_p0_data};
         if (w_p1 && w_p1_rd == rs) res = {1'b1, w_p1_data};
      end
      return res;
   endfunction

   // Bypass search for both decode read ports.
   always_comb begin
      w_look1 = f_lookup(rs1_i);
      w_look2 = f_lookup(rs2_i);
   end

   assign we3_o         = w_live & w_we;
   assign a3_o          = w_live ? w_a3 : '0;
   assign wd3_o         = w_live ? w_wd : '0;
   assign stall_o       = w_live & w_stall;
   assign fwd1_hit_o    = w_live & w_look1[XLEN];
   assign fwd1_data_o   = w_live ? w_look1[XLEN-1:0] : '0;
   assign fwd2_hit_o    = w_live & w_look2[XLEN];
   assign fwd2_data_o   = w_live ? w_look2[XLEN-1:0] : '0;
   assign pending_cnt_o = w_cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - table-driven self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        wb0_valid_i;
   logic [4:0]  wb0_rd_i;
   logic [31:0] wb0_data_i;
   logic        wb1_valid_i;
   logic [4:0]  wb1_rd_i;
   logic [31:0] wb1_data_i;
   logic        we3_o;
   logic [4:0]  a3_o;
   logic [31:0] wd3_o;
   logic        stall_o;
   logic [4:0]  rs1_i;
   logic [4:0]  rs2_i;
   logic        fwd1_hit_o;
   logic [31:0] fwd1_data_o;
   logic        fwd2_hit_o;
   logic [31:0] fwd2_data_o;
   logic [2:0]  pending_cnt_o;

   int checks;
   int failures;

   typedef struct {
      bit [31:0] v0, rd0, d0, v1, rd1, d1, rs1, rs2;
      bit [31:0] we, a3, wd, st, cnt, h1, f1, h2, f2;
   } vec_t;

   vec_t tbl [23];

   wb_port_arbiter #(.DEPTH(4), .XLEN(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wb0_valid_i   (wb0_valid_i),
      .wb0_rd_i      (wb0_rd_i),
      .wb0_data_i    (wb0_data_i),
      .wb1_valid_i   (wb1_valid_i),
      .wb1_rd_i      (wb1_rd_i),
      .wb1_data_i    (wb1_data_i),
      .we3_o         (we3_o),
      .a3_o          (a3_o),
      .wd3_o         (wd3_o),
      .stall_o       (stall_o),
      .rs1_i         (rs1_i),
      .rs2_i         (rs2_i),
      .fwd1_hit_o    (fwd1_hit_o),
      .fwd1_data_o   (fwd1_data_o),
      .fwd2_hit_o    (fwd2_hit_o),
      .fwd2_data_o   (fwd2_data_o),
      .pending_cnt_o (pending_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input bit [31:0] act, input bit [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit v0, input bit [4:0] rd0, input bit [31:0] d0,
                        input bit v1, input bit [4:0] rd1, input bit [31:0] d1,
                        input bit [4:0] r1, input bit [4:0] r2);
      wb0_valid_i = v0;
      wb0_rd_i    = rd0;
      wb0_data_i  = d0;
      wb1_valid_i = v1;
      wb1_rd_i    = rd1;
      wb1_data_i  = d1;
      rs1_i       = r1;
      rs2_i       = r2;
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      //          v0 rd0 d0      v1 rd1 d1      rs1 rs2   we a3  wd      st cnt h1 f1      h2 f2
      tbl[0]  = '{0, 0,  0,      0, 0,  0,      0,  0,    0, 0,  0,      0, 0,  0, 0,      0, 0};
      tbl[1]  = '{1, 5,  'h11,   0, 0,  0,      5,  0,    1, 5,  'h11,   0, 0,  0, 0,      0, 0};
      tbl[2]  = '{1, 3,  'hA,    1, 4,  'hB,    4,  3,    1, 3,  'hA,    0, 0,  1, 'hB,    0, 0};
      tbl[3]  = '{0, 0,  0,      0, 0,  0,      4,  0,    1, 4,  'hB,    0, 1,  0, 0,      0, 0};
      tbl[4]  = '{0, 0,  0,      0, 0,  0,      0,  0,    0, 0,  0,      0, 0,  0, 0,      0, 0};
      tbl[5]  = '{1, 1,  'h101,  1, 2,  'h102,  2,  1,    1, 1,  'h101,  0, 0,  1, 'h102,  0, 0};
      tbl[6]  = '{1, 3,  'h103,  1, 4,  'h104,  3,  2,    1, 2,  'h102,  0, 1,  1, 'h103,  0, 0};
      tbl[7]  = '{1, 5,  'h105,  1, 6,  'h106,  4,  6,    1, 3,  'h103,  0, 2,  1, 'h104,  1, 'h106};
      tbl[8]  = '{1, 7,  'h107,  1, 8,  'h108,  7,  5,    1, 4,  'h104,  1, 3,  0, 0,      1, 'h105};
      tbl[9]  = '{1, 7,  'h107,  1, 8,  'h108,  8,  6,    1, 5,  'h105,  0, 2,  1, 'h108,  1, 'h106};
      tbl[10] = '{0, 0,  0,      0, 0,  0,      7,  0,    1, 6,  'h106,  1, 3,  1, 'h107,  0, 0};
      tbl[11] = '{0, 0,  0,      0, 0,  0,      8,  0,    1, 7,  'h107,  0, 2,  1, 'h108,  0, 0};
      tbl[12] = '{0, 0,  0,      0, 0,  0,      8,  0,    1, 8,  'h108,  0, 1,  0, 0,      0, 0};
      tbl[13] = '{0, 0,  0,      0, 0,  0,      0,  0,    0, 0,  0,      0, 0,  0, 0,      0, 0};
      tbl[14] = '{1, 7,  'h22,   1, 0,  'h99,   0,  7,    1, 7,  'h22,   0, 0,  0, 0,      0, 0};
      tbl[15] = '{0, 0,  0,      0, 0,  0,      7,  0,    0, 0,  0,      0, 0,  0, 0,      0, 0};
      tbl[16] = '{1, 0,  'h44,   1, 10, 'h33,   10, 0,    1, 10, 'h33,   0, 0,  0, 0,      0, 0};
      tbl[17] = '{0, 0,  0,      0, 0,  0,      0,  0,    0, 0,  0,      0, 0,  0, 0,      0, 0};
      tbl[18] = '{1, 12, 'hC,    1, 13, 'hD,    13, 0,    1, 12, 'hC,    0, 0,  1, 'hD,    0, 0};
      tbl[19] = '{1, 9,  'h1,    1, 9,  'h2,    9,  0,    1, 13, 'hD,    0, 1,  1, 'h2,    0, 0};
      tbl[20] = '{0, 0,  0,      0, 0,  0,      9,  0,    1, 9,  'h1,    0, 2,  1, 'h2,    0, 0};
      tbl[21] = '{0, 0,  0,      0, 0,  0,      9,  0,    1, 9,  'h2,    0, 1,  0, 0,      0, 0};
      tbl[22] = '{0, 0,  0,      0, 0,  0,      0,  0,    0, 0,  0,      0, 0,  0, 0,      0, 0};

      // Reset with a live lane request: outputs must stay quiet.
      rst_n = 1'b0;
      drive(1, 5, 'h77, 1, 6, 'h78, 5, 6);
      repeat (2) @(negedge clk);
      #1;
      check("reset_we3",   32'(we3_o), 0);
      check("reset_a3",    32'(a3_o), 0);
      check("reset_wd3",   wd3_o, 0);
      check("reset_stall", 32'(stall_o), 0);
      check("reset_cnt",   32'(pending_cnt_o), 0);
      check("reset_fwd1",  32'(fwd1_hit_o), 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 23; i++) begin
         drive(tbl[i].v0[0], tbl[i].rd0[4:0], tbl[i].d0, tbl[i].v1[0], tbl[i].rd1[4:0], tbl[i].d1,
               tbl[i].rs1[4:0], tbl[i].rs2[4:0]);
         #1;
         check($sformatf("v%0d_we3", i),   32'(we3_o), tbl[i].we);
         check($sformatf("v%0d_a3", i),    32'(a3_o), tbl[i].a3);
         check($sformatf("v%0d_wd3", i),   wd3_o, tbl[i].wd);
         check($sformatf("v%0d_stall", i), 32'(stall_o), tbl[i].st);
         check($sformatf("v%0d_cnt", i),   32'(pending_cnt_o), tbl[i].cnt);
         check($sformatf("v%0d_fwd1h", i), 32'(fwd1_hit_o), tbl[i].h1);
         check($sformatf("v%0d_fwd1d", i), fwd1_data_o, tbl[i].f1);
         check($sformatf("v%0d_fwd2h", i), 32'(fwd2_hit_o), tbl[i].h2);
         check($sformatf("v%0d_fwd2d", i), fwd2_data_o, tbl[i].f2);
         @(negedge clk);
      end

      // Build two pending entries, then pull reset mid-cycle.
      drive(1, 1, 'hAA, 1, 2, 'hBB, 0, 0);
      #1;
      check("mr_a3_first", 32'(a3_o), 1);
      @(negedge clk);
      drive(1, 3, 'hCC, 1, 4, 'hDD, 0, 0);
      #1;
      check("mr_a3_head", 32'(a3_o), 2);
      check("mr_cnt1",    32'(pending_cnt_o), 1);
      @(negedge clk);
      drive(1, 5, 'h55, 0, 0, 0, 4, 0);
      #1;
      check("mr_cnt2",    32'(pending_cnt_o), 2);
      check("mr_a3_x3",   32'(a3_o), 3);
      check("mr_fwd1_x4", fwd1_data_o, 'hDD);
      #1;
      rst_n = 1'b0;
      #1;
      check("mr_async_we3",   32'(we3_o), 0);
      check("mr_async_a3",    32'(a3_o), 0);
      check("mr_async_wd3",   wd3_o, 0);
      check("mr_async_stall", 32'(stall_o), 0);
      check("mr_async_cnt",   32'(pending_cnt_o), 0);
      check("mr_async_fwd1",  32'(fwd1_hit_o), 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 4, 3);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         check($sformatf("post_rst%0d_we3", c), 32'(we3_o), 0);
         check($sformatf("post_rst%0d_cnt", c), 32'(pending_cnt_o), 0);
         check($sformatf("post_rst%0d_fwd", c), 32'(fwd1_hit_o | fwd2_hit_o), 0);
      end
      @(negedge clk);
      drive(1, 5, 'h11, 0, 0, 0, 0, 0);
      #1;
      check("post_lane0_we3", 32'(we3_o), 1);
      check("post_lane0_a3",  32'(a3_o), 5);
      check("post_lane0_wd3", wd3_o, 'h11);
      check("post_lane0_cnt", 32'(pending_cnt_o), 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("post_idle_we3", 32'(we3_o), 0);
      check("post_idle_cnt", 32'(pending_cnt_o), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single regfile write port (AD3/WD3/WE3) between the two writeback lanes of the dual-issue pipeline.
- Lane 0 is always the older instruction; program order of regfile writes is preserved.
- Writes that cannot be issued immediately are held in an in-order pending FIFO.
- Provides a bypass lookup so decode never reads a stale register while a write is pending, and raises a stall when buffering is exhausted.

Parameters:
- DEPTH, 4, pending FIFO entries; power of two, minimum 2.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wb0_valid_i  in  1  lane 0 (older) write request.
- wb0_rd_i  in  5  lane 0 destination.
- wb0_data_i  in  XLEN  lane 0 data.
- wb1_valid_i  in  1  lane 1 (younger) write request.
- wb1_rd_i  in  5  lane 1 destination.
- wb1_data_i  in  XLEN  lane 1 data.
- we3_o  out  1  regfile write enable.
- a3_o  out  5  regfile write address.
- wd3_o  out  XLEN  regfile write data.
- stall_o  out  1  upstream must hold writeback lanes.
- rs1_i  in  5  decode read address 1.
- rs2_i  in  5  decode read address 2.
- fwd1_hit_o  out  1  pending write matches rs1_i.
- fwd1_data_o  out  XLEN  youngest pending data for rs1_i.
- fwd2_hit_o  out  1  pending write matches rs2_i.
- fwd2_data_o  out  XLEN  youngest pending data for rs2_i.
- pending_cnt_o  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert internally): FIFO empty, pointers 0, count 0.
  - All outputs are 0 while in reset; stall_o=0.
  - Reset mid-operation discards pending writes.
- stall_o is combinational from the registered count: stall_o = (DEPTH - count) < 2.
- While stall_o=1:
  - Lane inputs are ignored; upstream holds and re-presents them.
  - Draining continues.
- Accepted lane entry: valid=1, stall_o=0, rd != 0. Writes to x0 are dropped silently.
- Per-cycle order list is: FIFO head..tail, then accepted lane 0, then accepted lane 1.
  - The first list element drives we3_o/a3_o/wd3_o combinationally in the same cycle; the regfile captures it on the clk edge.
  - If the first element is the FIFO head, it is popped.
  - Remaining accepted lane entries are pushed in order: lane 0 before lane 1.
  - Push and pop in the same cycle are legal.
  - Count update: count + pushes - pop.
- If the list is empty, we3_o=0 and a3_o/wd3_o hold 0.
- Latency:
  - With an empty FIFO, a lane 0 write commits in 0 cycles (same edge).
  - Lane 1 commits 1 cycle later when lane 0 is also accepted.
  - Otherwise the FIFO drains one entry per cycle.
- Overflow is impossible by construction. A push while full is an assertion failure in simulation.
- Bypass lookup is combinational. It searches FIFO entries plus this cycle's accepted lanes, excluding the element being written this cycle.
  - Priority is lane 1 > lane 0 > FIFO tail-to-head (youngest wins).
  - rsX_i = 0 never hits.
  - On miss, data output is 0.
- Pointer wrap is modulo DEPTH. count reaching DEPTH is legal.

Optional Feature:
- Macro: WB_WAW_COALESCE_EN.
- When defined: if both lanes are accepted with equal rd in the same cycle, lane 0 is discarded and only lane 1 enters the order list (one write instead of two).
- When undefined: both writes are performed in order.
- Architectural state is identical either way; only write count and FIFO occupancy differ.

Decomposition:
- Package wb_pkg holds:
  - typedef wb_req_t {valid, rd[4:0], data[XLEN-1:0]}.
  - Constant REG_X0 = 5'd0.
  - Constant WB_LANES = 2.
- One natural sub-module, wb_pending_fifo: storage, pointers, count, push0/push1/pop, and parallel entry visibility for the bypass search.
- Arbitration and lookup logic stays in the top module.

Test Plan:
- Reset, FIFO empty, lane0 {rd=5, 0x11} alone -> same cycle we3_o=1, a3_o=5, wd3_o=0x11; pending_cnt_o=0.
- Both lanes {rd=3, 0xA}, {rd=4, 0xB}, FIFO empty -> cycle 0 writes x3; cycle 1 writes x4 from FIFO; count goes 1 then 0.
- Three dual-issue cycles with DEPTH=4 -> count reaches 3; stall_o=1 (DEPTH-3 < 2); held lanes ignored until drain; write order exactly matches program order.
- Lane1 rd=0 with lane0 {rd=7, 0x22} -> only x7 written; nothing enqueued.
- FIFO holds x9=0x1 (older) and x9=0x2 (younger); rs1_i=9 -> fwd1_hit_o=1, fwd1_data_o=0x2. rs2_i=0 -> fwd2_hit_o=0.
- rst_n pulsed low with count=2 -> outputs 0 immediately (asynchronously); after release count=0 and no stale writes issue.
